// File: rtl/mips_gpio_port.sv
// mips_gpio_port: register-mapped GPIO for the multicycle MIPS data bus.
//   addr 0 OUT (rw, drives GPIO_o), 1 IN (ro, filtered pins),
//   addr 2 EDGE (sticky rising-edge flags, write-1-to-clear), 3 MASK (irq enables).
// Optional feature: define MIPS_GPIO_DEBOUNCE_EN to build the tick-sampled
// debouncer in front of IN (DebounceCycles sets the tick period).

// Per-pin front end: synchroniser chain, IN flop and rise detect.
// The IN flop is the last synchroniser stage, so a pin reaches IN after
// SyncStages edges and the edge flag fires on the same edge.
module mips_gpio_pin #(
  parameter int SyncStages = 2
) (
  input  logic clk,
  input  logic reset,
`ifdef MIPS_GPIO_DEBOUNCE_EN
  input  logic tick,
`endif
  input  logic pin,
  output logic in_q,
  output logic rise
);
  localparam int SW = SyncStages - 1;

  logic [SW-1:0] sync_r;
  logic          sync;
  logic          in_nxt;

  assign sync = sync_r[SW-1];

  // synchroniser shift chain, clears on reset so no edge is seen from reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) sync_r <= '0;
    else        sync_r <= SW'({sync_r, pin});

`ifdef MIPS_GPIO_DEBOUNCE_EN
  logic hist_q;

  // previous tick sample of the synchronised pin
  always_ff @(posedge clk or negedge reset)
    if (!reset)    hist_q <= 1'b0;
    else if (tick) hist_q <= sync;

  // accept a new level only when two consecutive tick samples agree
  always_comb begin
    in_nxt = in_q;
    if (tick && (sync == hist_q) && (sync != in_q)) in_nxt = sync;
  end
`else
  assign in_nxt = sync;
`endif

  // filtered pin state
  always_ff @(posedge clk or negedge reset)
    if (!reset) in_q <= 1'b0;
    else        in_q <= in_nxt;

  assign rise = in_nxt & ~in_q;
endmodule

module mips_gpio_port #(
  parameter int DataWidth      = 32,
  parameter int GpioWidth      = 8,
  parameter int SyncStages     = 2,
  parameter int DebounceCycles = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sel,
  input  logic                 we,
  input  logic [1:0]           addr,
  input  logic [DataWidth-1:0] wdata,
  output logic [DataWidth-1:0] rdata,
  output logic                 rvalid,
  input  logic [GpioWidth-1:0] GPIO_i,
  output logic [GpioWidth-1:0] GPIO_o,
  output logic                 irq
);
  localparam logic [1:0] A_OUT = 2'd0, A_IN = 2'd1, A_EDGE = 2'd2, A_MASK = 2'd3;

  logic [GpioWidth-1:0] out_q, mask_q, edge_q, edge_d, in_q, rise, w1c, rd_mux, wd;
  logic                 wr, rd;

  assign wr = sel & we;
  assign rd = sel & ~we;
  assign wd = wdata[GpioWidth-1:0];

  if (DataWidth > GpioWidth) begin : g_wd_hi
    logic unused_wdata;
    assign unused_wdata = ^wdata[DataWidth-1:GpioWidth];
  end

`ifdef MIPS_GPIO_DEBOUNCE_EN
  localparam int CW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  logic [CW-1:0] pre_q;
  logic          tick;

  assign tick = (pre_q == CW'(DebounceCycles - 1));

  // shared prescaler, wraps at terminal count
  always_ff @(posedge clk or negedge reset)
    if (!reset)    pre_q <= '0;
    else if (tick) pre_q <= '0;
    else           pre_q <= pre_q + 1'b1;

  mips_gpio_pin #(.SyncStages(SyncStages)) u_pin [GpioWidth-1:0] (
    .clk(clk), .reset(reset), .tick(tick), .pin(GPIO_i), .in_q(in_q), .rise(rise));
`else
  mips_gpio_pin #(.SyncStages(SyncStages)) u_pin [GpioWidth-1:0] (
    .clk(clk), .reset(reset), .pin(GPIO_i), .in_q(in_q), .rise(rise));
`endif

  // a fresh rise on the same edge as a W1C keeps the flag set
  assign w1c    = (wr && addr == A_EDGE) ? wd : '0;
  assign edge_d = (edge_q & ~w1c) | rise;

  // read mux over current register contents
  always_comb begin
    rd_mux = '0;
    case (addr)
      A_OUT:  rd_mux = out_q;
      A_IN:   rd_mux = in_q;
      A_EDGE: rd_mux = edge_q;
      A_MASK: rd_mux = mask_q;
      default: rd_mux = '0;
    endcase
  end

  // control registers and edge flags
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      out_q  <= '0;
      mask_q <= '0;
      edge_q <= '0;
    end else begin
      edge_q <= edge_d;
      if (wr && addr == A_OUT)  out_q  <= wd;
      if (wr && addr == A_MASK) mask_q <= wd;
    end

  // registered read port: rdata holds, rvalid pulses one cycle per read
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd;
      if (rd) rdata <= DataWidth'(rd_mux);
    end

  // interrupt, one edge behind EDGE/MASK
  always_ff @(posedge clk or negedge reset)
    if (!reset) irq <= 1'b0;
    else        irq <= |(edge_q & mask_q);

  assign GPIO_o = out_q;
endmodule

// File: tb/tb_mips_gpio_port.sv
// Scoreboard bench for mips_gpio_port (default build, no debounce).
module tb_mips_gpio_port;
  localparam int DW = 32, GW = 8, SS = 2;

  logic          clk = 1'b0, reset = 1'b0;
  logic          sel = 1'b0, we = 1'b0;
  logic [1:0]    addr = '0;
  logic [DW-1:0] wdata = '0, rdata;
  logic          rvalid, irq;
  logic [GW-1:0] gpio_i = '0, gpio_o;

  mips_gpio_port #(.DataWidth(DW), .GpioWidth(GW), .SyncStages(SS), .DebounceCycles(4)) dut (
    .clk(clk), .reset(reset), .sel(sel), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .GPIO_i(gpio_i), .GPIO_o(gpio_o), .irq(irq));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [DW-1:0] exp_q[$];

  // reference model: registers plus a delay line of pin samples
  logic [GW-1:0] m_out, m_in, m_edge, m_mask;
  logic          m_irq;
  logic [GW-1:0] pin_hist[$];
  logic [GW-1:0] pins = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_out = '0; m_in = '0; m_edge = '0; m_mask = '0; m_irq = 1'b0;
    pin_hist.delete();
    for (int i = 0; i < SS - 1; i++) pin_hist.push_back('0);
  endfunction

  // one clock edge of the model; returns what a read this cycle yields
  function automatic logic [DW-1:0] m_clock(input bit s, input bit w, input logic [1:0] a,
                                            input logic [DW-1:0] d, input logic [GW-1:0] p);
    logic [GW-1:0] in_new, clr, rv;
    in_new = pin_hist.pop_back();
    pin_hist.push_front(p);
    case (a)
      2'd0: rv = m_out;
      2'd1: rv = m_in;
      2'd2: rv = m_edge;
      default: rv = m_mask;
    endcase
    m_irq  = |(m_edge & m_mask);
    clr    = (s && w && a == 2'd2) ? d[GW-1:0] : '0;
    m_edge = (m_edge & ~clr) | (in_new & ~m_in);
    m_in   = in_new;
    if (s && w && a == 2'd0) m_out  = d[GW-1:0];
    if (s && w && a == 2'd3) m_mask = d[GW-1:0];
    return {{(DW-GW){1'b0}}, rv};
  endfunction

  task automatic step(input bit s, input bit w, input logic [1:0] a, input logic [DW-1:0] d,
                      input bit use_c = 1'b0, input logic [DW-1:0] cexp = '0);
    logic [DW-1:0] rv;
    @(negedge clk);
    sel = s; we = w; addr = a; wdata = d; gpio_i = pins;
    rv = m_clock(s, w, a, d, pins);
    if (s && !w) exp_q.push_back(use_c ? cexp : rv);
    @(posedge clk); #1;
    chk("gpio_o", {24'h0, gpio_o}, {24'h0, m_out});
    chk("irq", {31'h0, irq}, {31'h0, m_irq});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, '0);
  endtask

  // monitor: every rvalid pulse must match the oldest queued read
  initial forever begin
    @(posedge clk); #1;
    if (reset === 1'b1 && rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rvalid_unexpected actual=1 expected=0 t=%0t", $time);
      end else chk("rdata", rdata, exp_q.pop_front());
    end
  end

  initial begin
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gpio_o", {24'h0, gpio_o}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    @(negedge clk) reset = 1'b1;

    // state to be wiped by a reset that lands mid-write
    step(1, 1, 2'd0, 32'h33);
    step(1, 1, 2'd3, 32'hFF);
    @(negedge clk);
    sel = 1; we = 1; addr = 2'd0; wdata = 32'hFF;
    #2 reset = 1'b0;
    m_reset();
    @(posedge clk); #1;
    chk("midrst_gpio_o", {24'h0, gpio_o}, 32'h0);
    chk("midrst_irq", {31'h0, irq}, 32'h0);
    chk("midrst_rvalid", {31'h0, rvalid}, 32'h0);
    chk("midrst_rdata", rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1; sel = 0;
    step(1, 0, 2'd3, '0, 1, 32'h0);

    // OUT write/readback and upper-bit masking
    step(1, 1, 2'd0, 32'h5A);
    step(1, 0, 2'd0, '0, 1, 32'h0000_005A);
    chk("out_5a", {24'h0, gpio_o}, 32'h5A);
    step(1, 1, 2'd0, 32'hFFFF_FF00);
    chk("out_ff00", {24'h0, gpio_o}, 32'h0);

    // edge -> irq timing, then W1C
    step(1, 1, 2'd3, 32'h01);
    idle(2);
    pins = 8'h01;
    idle(1);                          // edge N
    chk("irq_n", {31'h0, irq}, 32'h0);
    idle(1);                          // edge N+1: EDGE set
    chk("irq_n1", {31'h0, irq}, 32'h0);
    step(1, 0, 2'd2, '0, 1, 32'h01);  // edge N+2
    chk("irq_n2", {31'h0, irq}, 32'h1);
    step(1, 1, 2'd2, 32'h01);
    chk("irq_w1c_edge", {31'h0, irq}, 32'h1);
    idle(1);
    chk("irq_w1c_after", {31'h0, irq}, 32'h0);

    // set beats clear on bit 1
    pins = 8'h02; idle(3);
    pins = 8'h00; idle(3);
    pins = 8'h02; idle(1);
    step(1, 1, 2'd2, 32'h03);         // W1C on the edge IN[1] rises
    step(1, 0, 2'd2, '0, 1, 32'h02);

    // masking
    step(1, 1, 2'd3, 32'h00);
    pins = 8'h00; idle(3);
    step(1, 1, 2'd2, 32'hFF);
    pins = 8'hF0; idle(3);
    step(1, 0, 2'd2, '0, 1, 32'hF0);
    step(1, 0, 2'd1, '0, 1, 32'hF0);
    chk("mask0_irq", {31'h0, irq}, 32'h0);
    step(1, 1, 2'd3, 32'h10);
    chk("mask10_irq_edge", {31'h0, irq}, 32'h0);
    idle(1);
    chk("mask10_irq_after", {31'h0, irq}, 32'h1);

    // writes to IN are dropped
    step(1, 1, 2'd1, 32'h0F);
    step(1, 0, 2'd1, '0, 1, 32'hF0);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) pins = GW'($urandom);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
    end
    idle(2);
    chk("reads_outstanding", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
